// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared types and default widths for the register-file writeback arbiter.
package regfile_wb_pkg;
  localparam int WB_ADDR_W     = 5;
  localparam int WB_DATA_W     = 32;
  localparam int WB_FIFO_DEPTH = 2;
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;
  typedef enum logic [1:0] {WB_SRC_ALU, WB_SRC_LSU, WB_SRC_MUL} wb_src_e;
endpackage

// File: rtl/wb_req_fifo.sv
// wb_req_fifo: FIFO_DEPTH-entry wb_req_t queue with per-entry valid/address view for hazard tracking.
module wb_req_fifo
  import regfile_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_push,
  input  logic                                 i_pop,
  input  wb_req_t                              i_req,
  output logic [$clog2(FIFO_DEPTH):0]          o_count,
  output logic                                 o_full,
  output logic                                 o_empty,
  output wb_req_t                              o_head,
  output logic [FIFO_DEPTH-1:0]                o_valid,
  output logic [FIFO_DEPTH-1:0][WB_ADDR_W-1:0] o_addr
);
  localparam int PW = $clog2(FIFO_DEPTH);
  wb_req_t r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [PW:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_req;
  assign o_count = r_cnt;
  assign o_full  = r_cnt == (PW+1)'(FIFO_DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_head  = r_mem[r_rd];
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_view
    logic [PW-1:0] w_off;
    assign w_off      = PW'(i) - r_rd;
    assign o_valid[i] = {1'b0, w_off} < r_cnt;
    assign o_addr[i]  = r_mem[i].addr;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU, LSU and multi-cycle writebacks onto two register-file write ports.
// Optional macro WB_ARB_REG0_DROP_EN discards all writes to register 0.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    src0_valid_i,
  input  logic [ADDR_WIDTH-1:0]   src0_addr_i,
  input  logic [DATA_WIDTH-1:0]   src0_data_i,
  input  logic                    src1_valid_i,
  output logic                    src1_ready_o,
  input  logic [ADDR_WIDTH-1:0]   src1_addr_i,
  input  logic [DATA_WIDTH-1:0]   src1_data_i,
  input  logic                    src2_valid_i,
  output logic                    src2_ready_o,
  input  logic [ADDR_WIDTH-1:0]   src2_addr_i,
  input  logic [DATA_WIDTH-1:0]   src2_data_i,
  output logic                    we_a_o,
  output logic [ADDR_WIDTH-1:0]   waddr_a_o,
  output logic [DATA_WIDTH-1:0]   wdata_a_o,
  output logic                    we_b_o,
  output logic [ADDR_WIDTH-1:0]   waddr_b_o,
  output logic [DATA_WIDTH-1:0]   wdata_b_o,
  output logic [2**ADDR_WIDTH-1:0] pend_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef WB_ARB_REG0_DROP_EN
  localparam bit DROP0 = 1'b1;
`else
  localparam bit DROP0 = 1'b0;
`endif
  wb_req_t w_head1, w_head2;
  logic [CW-1:0] w_cnt1, w_cnt2;
  logic w_full1, w_full2, w_empty1, w_empty2;
  logic [FIFO_DEPTH-1:0] w_val1, w_val2;
  logic [FIFO_DEPTH-1:0][WB_ADDR_W-1:0] w_adr1, w_adr2;
  logic w_v0, w_push1, w_push2, w_c1, w_c2, w_pick, w_iss1, w_iss2, w_unused;
  logic r_rr;
  assign w_unused     = ^{w_cnt1, w_cnt2};
  assign src1_ready_o = !w_full1;
  assign src2_ready_o = !w_full2;
  // register-0 writes complete their handshake but are never queued or driven
  assign w_v0    = src0_valid_i && !(DROP0 && src0_addr_i == '0);
  assign w_push1 = src1_valid_i && src1_ready_o && !(DROP0 && src1_addr_i == '0);
  assign w_push2 = src2_valid_i && src2_ready_o && !(DROP0 && src2_addr_i == '0);
  wb_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .i_push(w_push1), .i_pop(w_iss1),
    .i_req('{addr: src1_addr_i, data: src1_data_i}),
    .o_count(w_cnt1), .o_full(w_full1), .o_empty(w_empty1), .o_head(w_head1),
    .o_valid(w_val1), .o_addr(w_adr1)
  );
  wb_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk(clk), .rst(rst), .i_push(w_push2), .i_pop(w_iss2),
    .i_req('{addr: src2_addr_i, data: src2_data_i}),
    .o_count(w_cnt2), .o_full(w_full2), .o_empty(w_empty2), .o_head(w_head2),
    .o_valid(w_val2), .o_addr(w_adr2)
  );
  // a head colliding with src0 yields; two survivors share one slot (src0 busy) or one address
  assign w_c1   = !w_empty1 && !(w_v0 && w_head1.addr == src0_addr_i);
  assign w_c2   = !w_empty2 && !(w_v0 && w_head2.addr == src0_addr_i);
  assign w_pick = w_c1 && w_c2 && (w_v0 || w_head1.addr == w_head2.addr);
  assign w_iss1 = w_c1 && !(w_pick && r_rr);
  assign w_iss2 = w_c2 && !(w_pick && !r_rr);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rr <= 1'b0;
    else if (w_pick) r_rr <= !r_rr;
  assign we_a_o    = !rst && (w_v0 || w_iss1);
  assign waddr_a_o = w_v0 ? src0_addr_i : w_head1.addr;
  assign wdata_a_o = w_v0 ? src0_data_i : w_head1.data;
  assign we_b_o    = !rst && (w_iss2 || (w_v0 && w_iss1));
  assign waddr_b_o = (w_v0 && w_iss1) ? w_head1.addr : w_head2.addr;
  assign wdata_b_o = (w_v0 && w_iss1) ? w_head1.data : w_head2.data;
  always_comb begin
    pend_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_val1[i]) pend_o[w_adr1[i]] = 1'b1;
      if (w_val2[i]) pend_o[w_adr2[i]] = 1'b1;
    end
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback arbiter directly upstream of the 3-read/2-write latch register file.
- Merges three writeback sources onto the file's two write ports:
  - src0: ALU; always accepted, no backpressure.
  - src1: LSU; valid/ready.
  - src2: multi-cycle unit; valid/ready.
- src1 and src2 each have a small FIFO.
- Never drives the same address on both ports in one cycle.
- Exports a pending-write bitmap for hazard detection.

Parameters:
- ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, write data width.
- FIFO_DEPTH, 2, entries per buffered source; power of two, >=2.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- src0_valid_i  in  1  ALU writeback valid.
- src0_addr_i  in  ADDR_WIDTH  ALU destination.
- src0_data_i  in  DATA_WIDTH  ALU result.
- src1_valid_i  in  1  LSU writeback valid.
- src1_ready_o  out  1  LSU FIFO not full.
- src1_addr_i  in  ADDR_WIDTH  LSU destination.
- src1_data_i  in  DATA_WIDTH  LSU data.
- src2_valid_i  in  1  multi-cycle writeback valid.
- src2_ready_o  out  1  multi-cycle FIFO not full.
- src2_addr_i  in  ADDR_WIDTH  multi-cycle destination.
- src2_data_i  in  DATA_WIDTH  multi-cycle data.
- we_a_o  out  1  to register file write port A enable.
- waddr_a_o  out  ADDR_WIDTH  port A address.
- wdata_a_o  out  DATA_WIDTH  port A data.
- we_b_o  out  1  to register file write port B enable.
- waddr_b_o  out  ADDR_WIDTH  port B address.
- wdata_b_o  out  DATA_WIDTH  port B data.
- pend_o  out  NUM_WORDS  bit r set while any FIFO entry targets register r.

Behaviour:
- Reset (rst=1, async):
  - Both FIFOs flushed; rr_q=0 (src1 favoured).
  - pend_o=0; src1_ready_o=src2_ready_o=1.
  - we_a_o=we_b_o=0 forced while rst high, including src0 pass-through.
- Enqueue:
  - srcN accepted when valid && ready; entry stored at the clock edge.
  - Earliest issue is the next cycle, so buffered latency is 1 cycle.
  - Entries issue in FIFO order per source; no ordering is kept between sources.
- src0 path: combinational, 0-cycle latency. When src0_valid_i=1, it always takes port A.
- Slot assignment each cycle; H1/H2 are the FIFO1/FIFO2 heads:
  - src0 valid, one head present: that head takes port B.
  - src0 valid, both heads present: the rr_q winner takes port B; rr_q toggles.
  - src0 idle: H1 takes port A, H2 takes port B.
- Address conflict:
  - Two candidates with equal addresses: only the higher-priority one issues; the other stays queued.
  - Priority is src0 first, then the rr_q winner.
  - When both heads collide with src0 idle, the rr_q winner issues and rr_q toggles.
  - Ports A and B never carry equal addresses with both enables high.
- Dequeue:
  - A head pops at the edge of the cycle in which it issued.
  - Simultaneous pop and push on a full FIFO is allowed. ready is computed from registered occupancy only, so a full FIFO stays not-ready that cycle.
- FIFO boundaries:
  - Full: ready=0; valid held by the source.
  - Empty: no issue from that FIFO.
  - Pointers wrap modulo FIFO_DEPTH; separate count register of width $clog2(FIFO_DEPTH)+1.
- pend_o: OR-decode of the addresses of all valid entries in both FIFOs, from registered state only. src0 never sets pend_o.
- Outputs are combinational from registered FIFO state plus the src0 inputs. we_* drive the register file clock gating, so they must be glitch-free relative to clk: no logic on clk.

Optional Feature:
- Macro: WB_ARB_REG0_DROP_EN.
- Defined:
  - Writes to address 0 from any source are accepted but discarded.
  - src0 to address 0 never asserts we_a_o.
  - Buffered entries to address 0 are never enqueued and never set pend_o[0].
  - They pop without occupying a slot.
- Undefined: address 0 is treated like any other register.

Decomposition:
- Package regfile_wb_pkg:
  - wb_req_t packed struct {addr, data}, parameterised via localparam widths.
  - wb_src_e enum {WB_SRC_ALU, WB_SRC_LSU, WB_SRC_MUL}.
  - Default width constants.
- One sub-module: wb_req_fifo.
  - Generic FIFO_DEPTH-entry wb_req_t FIFO.
  - Outputs: count, full, empty, head, plus a per-entry valid/addr view for pend_o.
  - Instantiated twice.

Test Plan:
- Reset mid-traffic: fill FIFO1 with 2 entries, pulse rst -> same cycle we_a_o=we_b_o=0, pend_o=0, both ready=1, and no queued write appears after release.
- Three-way contention:
  - Stimulus: src0 addr 3, src1 addr 5, src2 addr 7, all at cycle 0.
  - Cycle 0: port A = addr 3.
  - Cycle 1: src0 is also valid with addr 9 → port A = addr 9, port B = addr 5 (rr_q=0); rr_q toggles.
  - Cycle 2: addr 7 issues on port B.
- Address conflict:
  - Stimulus: FIFO1 head addr 4 data 0xAA, FIFO2 head addr 4 data 0xBB, src0 idle, rr_q=0.
  - Required: only 0xAA is written in cycle N; 0xBB is written in cycle N+1; the ports never show equal addresses with both enables high.
- Backpressure, FIFO_DEPTH=2:
  - Stimulus: src1 drives 3 back-to-back entries while src0 is continuously valid and src2 keeps FIFO2 non-empty.
  - Required: src1_ready_o drops after 2 accepts; no entry is lost; write order on the ports is 1,2,3.
- pend_o: enqueue src2 addr 12 while blocked → pend_o[12]=1 until the edge after issue; pend_o returns to 0.
- With WB_ARB_REG0_DROP_EN: src0 addr 0 and src1 addr 0 → we_a_o/we_b_o stay 0, pend_o[0]=0, src1 entry consumed.
